// File: rtl/data_mem.sv
// Word-organised data memory with byte/half/word stores, one-cycle registered reads,
// and a post-reset zeroing sweep that holds off all requests until every word is cleared.
module data_mem #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        mem_en,
  input  logic        mem_rw_mode,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  store_control,
  output logic [31:0] mem_data,
  output logic        mem_busy,
  output logic        mem_misaligned
);

  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  // Store encodings shared with the processor core; anything else is a no-op.
  localparam logic [2:0] ST_NOP = 3'd0;
  localparam logic [2:0] ST_SB  = 3'd1;
  localparam logic [2:0] ST_SH  = 3'd2;
  localparam logic [2:0] ST_SW  = 3'd3;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                              r_state, w_next;
  logic [AW-1:0]                       r_cnt;
  logic [AW-1:0]                       w_idx, w_waddr;
  logic [NUM_LANES-1:0]                w_we;
  logic                                w_rd, w_mis, r_mis;
  logic [NUM_LANES-1:0][LANE_W-1:0]    w_lane_rd;
  logic                                w_addr_unused;

  assign w_idx         = mem_addr[AW+1:2];
  assign w_addr_unused = ^mem_addr[31:AW+2];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state == S_CLEAR && r_cnt == AW'(DEPTH_WORDS - 1)) w_next = S_RUN;
  end

  always_comb begin
    mem_busy = 1'b0;
    w_we     = '0;
    w_rd     = 1'b0;
    w_mis    = 1'b0;
    w_waddr  = w_idx;
    case (r_state)
      S_CLEAR: begin
        mem_busy = 1'b1;
        w_we     = '1;
        w_waddr  = r_cnt;
      end
      S_RUN: begin
        if (mem_en) begin
          if (mem_rw_mode) begin
            w_rd = 1'b1;
          end else begin
            case (store_control)
              ST_SB: w_we = 4'b0001 << mem_addr[1:0];
              ST_SH: begin
                if (mem_addr[0]) w_mis = 1'b1;
                else             w_we  = mem_addr[1] ? 4'b1100 : 4'b0011;
              end
              ST_SW: begin
                if (|mem_addr[1:0]) w_mis = 1'b1;
                else                w_we  = '1;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_mis <= 1'b0;
    else        r_mis <= w_mis;
  end

  assign mem_misaligned = r_mis;

  // Each byte lane owns its own storage; stores steer the right-aligned source bytes to it.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [LANE_W-1:0] r_mem [DEPTH_WORDS];
    logic [LANE_W-1:0] r_rd;
    logic [LANE_W-1:0] w_wd;

    assign w_wd = (r_state == S_CLEAR)    ? '0 :
                  (store_control == ST_SW) ? mem_wdata[LANE_W*k +: LANE_W] :
                  (store_control == ST_SH) ? mem_wdata[LANE_W*(k%2) +: LANE_W] :
                                             mem_wdata[LANE_W-1:0];

    always_ff @(posedge i_clk) begin
      if (w_we[k]) r_mem[w_waddr] <= w_wd;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)    r_rd <= '0;
      else if (w_rd) r_rd <= r_mem[w_idx];
    end

    assign w_lane_rd[k] = r_rd;
  end

  assign mem_data = w_lane_rd;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem (DEPTH_WORDS=16): directed vector table, reset/sweep sequences,
// then random traffic checked against a word-array reference model.
module tb_data_mem;

  localparam int DEPTH = 16;
  localparam logic [2:0] ST_NOP = 3'd0;
  localparam logic [2:0] ST_SB  = 3'd1;
  localparam logic [2:0] ST_SH  = 3'd2;
  localparam logic [2:0] ST_SW  = 3'd3;

  logic        i_clk, i_rst;
  logic        mem_en, mem_rw_mode;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  store_control;
  logic [31:0] mem_data;
  logic        mem_busy, mem_misaligned;

  data_mem #(.DEPTH_WORDS(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .mem_en(mem_en), .mem_rw_mode(mem_rw_mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .store_control(store_control),
    .mem_data(mem_data), .mem_busy(mem_busy), .mem_misaligned(mem_misaligned)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic        en;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  st;
    logic [31:0] exp_d;
    logic        exp_m;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_data;
  logic        m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] st);
    mem_en = en; mem_rw_mode = rw; mem_addr = addr; mem_wdata = wd; store_control = st;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic add(input logic en, input logic rw, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [2:0] st,
                     input logic [31:0] exp_d, input logic exp_m);
    tbl.push_back('{en, rw, addr, wd, st, exp_d, exp_m});
  endtask

  // Counts samples with mem_busy high, starting right after reset release.
  task automatic sweep_count(input bit inject);
    int n = 0;
    while (mem_busy && n < 100) begin
      check("sweep_data", mem_data, 32'h0);
      check("sweep_mis", {31'b0, mem_misaligned}, 32'h0);
      if (inject) begin
        if (n == 3) drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, ST_SW);
        else        drive(1'b0, 1'b0, 32'h0, 32'h0, ST_NOP);
      end
      step();
      n++;
    end
    check("sweep_len", n, DEPTH);
    drive(1'b0, 1'b0, 32'h0, 32'h0, ST_NOP);
  endtask

  task automatic model(input logic en, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] st);
    int unsigned w = (addr >> 2) % DEPTH;
    int unsigned b = addr % 4;
    m_mis = 1'b0;
    if (en) begin
      if (rw) m_data = m_mem[w];
      else begin
        case (st)
          ST_SB: m_mem[w] = (m_mem[w] & ~(32'hFF << (8*b))) | ((wd & 32'hFF) << (8*b));
          ST_SH: begin
            if (b % 2 != 0) m_mis = 1'b1;
            else m_mem[w] = (m_mem[w] & ~(32'hFFFF << (8*b))) | ((wd & 32'hFFFF) << (8*b));
          end
          ST_SW: begin
            if (b != 0) m_mis = 1'b1;
            else        m_mem[w] = wd;
          end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    logic        en, rw;
    logic [31:0] addr, wd;
    logic [2:0]  st;

    // Directed table, applied after the first sweep completes.
    add(1, 1, 32'h0000_0000, 32'h0,          ST_NOP, 32'h0000_0000, 0);
    add(1, 1, 32'h0000_003C, 32'h0,          ST_NOP, 32'h0000_0000, 0);
    add(1, 0, 32'h0000_0008, 32'hDEAD_BEEF,  ST_SW,  32'h0000_0000, 0);
    add(1, 1, 32'h0000_0008, 32'h0,          ST_NOP, 32'hDEAD_BEEF, 0);
    add(1, 0, 32'h0000_000A, 32'h0000_00AA,  ST_SB,  32'hDEAD_BEEF, 0);
    add(1, 1, 32'h0000_0008, 32'h0,          ST_NOP, 32'hDEAA_BEEF, 0);
    add(1, 0, 32'h0000_0006, 32'h0000_1234,  ST_SH,  32'hDEAA_BEEF, 0);
    add(1, 1, 32'h0000_0004, 32'h0,          ST_NOP, 32'h1234_0000, 0);
    add(1, 0, 32'h0000_0005, 32'h0000_5678,  ST_SH,  32'h1234_0000, 1);
    add(1, 1, 32'h0000_0004, 32'h0,          ST_NOP, 32'h1234_0000, 0);
    add(1, 0, 32'h0000_0002, 32'h1111_1111,  ST_SW,  32'h1234_0000, 1);
    add(1, 1, 32'h0000_0000, 32'h0,          ST_NOP, 32'h0000_0000, 0);
    add(1, 0, 32'h0000_0000, 32'hCAFE_F00D,  ST_SW,  32'h0000_0000, 0);
    add(1, 1, 32'h0000_0040, 32'h0,          ST_NOP, 32'hCAFE_F00D, 0);
    add(0, 0, 32'h0000_0000, 32'h0,          ST_SW,  32'hCAFE_F00D, 0);
    add(1, 0, 32'h0000_0000, 32'h0,          ST_NOP, 32'hCAFE_F00D, 0);
    add(1, 0, 32'h0000_0000, 32'h0,          3'd7,   32'hCAFE_F00D, 0);
    add(1, 1, 32'h0000_0000, 32'h0,          ST_NOP, 32'hCAFE_F00D, 0);
    add(0, 1, 32'h0000_0008, 32'h0,          ST_NOP, 32'hCAFE_F00D, 0);
    add(1, 0, 32'h0000_0003, 32'h0000_0055,  ST_SB,  32'hCAFE_F00D, 0);
    add(1, 1, 32'hFFFF_FFC0, 32'h0,          ST_NOP, 32'h55FE_F00D, 0);

    i_rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, ST_NOP);
    #12;
    check("rst_data", mem_data, 32'h0);
    check("rst_busy", {31'b0, mem_busy}, 32'h1);
    check("rst_mis", {31'b0, mem_misaligned}, 32'h0);
    step();
    i_rst = 1'b1;
    sweep_count(1'b1);

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].rw, tbl[i].addr, tbl[i].wd, tbl[i].st);
      step();
      check($sformatf("vec%0d_data", i), mem_data, tbl[i].exp_d);
      check($sformatf("vec%0d_mis", i), {31'b0, mem_misaligned}, {31'b0, tbl[i].exp_m});
    end

    // Reset in the middle of a read: outputs drop at once, full sweep follows.
    drive(1'b1, 1'b1, 32'h0000_0008, 32'h0, ST_NOP);
    step();
    check("preread_data", mem_data, 32'hDEAA_BEEF);
    drive(1'b1, 1'b1, 32'h0000_0000, 32'h0, ST_NOP);
    #2 i_rst = 1'b0;
    #1;
    check("midread_data", mem_data, 32'h0);
    check("midread_busy", {31'b0, mem_busy}, 32'h1);
    #1 i_rst = 1'b1;
    // Read request stays asserted through part of the sweep and must be ignored.
    repeat (5) begin
      step();
      check("sweep_hold", mem_data, 32'h0);
    end
    // Reset again mid-sweep: the counter must start over.
    i_rst = 1'b0;
    #1;
    check("midsweep_busy", {31'b0, mem_busy}, 32'h1);
    check("midsweep_data", mem_data, 32'h0);
    #1 i_rst = 1'b1;
    sweep_count(1'b0);
    drive(1'b1, 1'b1, 32'h0000_0008, 32'h0, ST_NOP);
    step();
    check("cleared_w2", mem_data, 32'h0);
    drive(1'b1, 1'b1, 32'h0000_0000, 32'h0, ST_NOP);
    step();
    check("cleared_w0", mem_data, 32'h0);

    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_data = 32'h0;
    m_mis  = 1'b0;

    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      rw   = $urandom_range(0, 1) == 1;
      addr = $urandom_range(0, 1) == 1 ? $urandom : ($urandom & 32'h0000_000F);
      wd   = $urandom;
      st   = 3'($urandom_range(0, 7));
      model(en, rw, addr, wd, st);
      drive(en, rw, addr, wd, st);
      step();
      check("rnd_data", mem_data, m_data);
      check("rnd_mis", {31'b0, mem_misaligned}, {31'b0, m_mis});
    end

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 32'(i * 4), 32'h0, ST_NOP);
      step();
      check($sformatf("final_w%0d", i), mem_data, m_mem[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words (power of two, at least 4).
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port mem_en, input, 1 bit: access request this cycle.
REQ-005 The block SHALL have port mem_rw_mode, input, 1 bit: 1 = read, 0 = write.
REQ-006 The block SHALL have port mem_addr, input, 32 bits: byte address.
REQ-007 The block SHALL have port mem_wdata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 The block SHALL have port store_control, input, 3 bits: `ST_NOP / `SB / `SH / `SW encodings from processor_defines.sv.
REQ-009 The block SHALL have port mem_data, output, 32 bits: registered read data, full aligned word.
REQ-010 The block SHALL have port mem_busy, output, 1 bit: high while the post-reset clear sweep runs.
REQ-011 The block SHALL have port mem_misaligned, output, 1 bit: one-cycle pulse on a rejected misaligned store.

Function
REQ-012 The word index SHALL be mem_addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored (addresses wrap modulo DEPTH_WORDS*4).
REQ-013 The FSM SHALL have two states, CLEAR and RUN; reset enters CLEAR with sweep counter 0.
REQ-014 CLEAR: each cycle write 0 to word[counter], increment counter; after the write to word DEPTH_WORDS-1, go to RUN on the same edge.
REQ-015 mem_busy SHALL be 1 in CLEAR and 0 in RUN; the sweep takes exactly DEPTH_WORDS cycles after reset deassertion.
REQ-016 In CLEAR, all requests SHALL be ignored: no write, mem_data holds 0, mem_misaligned stays 0.
REQ-017 RUN read (mem_en=1, mem_rw_mode=1): on the rising edge, mem_data <= word[index]; latency is one cycle, so data is valid the cycle after the address is presented.
REQ-018 When no read is issued, mem_data SHALL hold its last value.
REQ-019 RUN write (mem_en=1, mem_rw_mode=0) with `SW and addr[1:0]=0 SHALL write all four bytes from mem_wdata.
REQ-020 `SH with addr[0]=0 SHALL write only lane addr[1] (bytes 1:0 or 3:2) with mem_wdata[15:0]; other bytes keep their values.
REQ-021 `SB SHALL write only byte lane addr[1:0] with mem_wdata[7:0]; it is never misaligned.
REQ-022 `SH with addr[0]=1, or `SW with addr[1:0]!=0, SHALL leave memory unchanged and pulse mem_misaligned high for one cycle, registered on the edge following the request.
REQ-023 A write with `ST_NOP, or any request with mem_en=0, SHALL have no effect.
REQ-024 A write SHALL leave mem_data unchanged (single port, no write-through).
REQ-025 A read issued the cycle after a write to the same word SHALL return the updated word.
REQ-026 Undefined store_control encodings SHALL be treated as `ST_NOP.

Reset
REQ-027 Asserting i_rst low at any time, including mid-sweep or mid-access, SHALL immediately force mem_data=0, mem_misaligned=0, mem_busy=1, state CLEAR, counter 0.
REQ-028 The sweep SHALL restart from word 0 after every reset; memory contents are not reset asynchronously, only cleared by the sweep.

Verification
REQ-029 Reset release, DEPTH_WORDS=16 -> mem_busy=1 for exactly 16 cycles then 0; a read of any address then returns 0x00000000.
REQ-030 SW 0xDEADBEEF @0x8, then read @0x8 -> 0xDEADBEEF one cycle after the read address; SB 0xAA @0xA, then read @0x8 -> 0xDEAABEEF.
REQ-031 SH 0x1234 @0x6 over a word holding 0 -> read @0x4 returns 0x12340000; SH @0x5 -> mem_misaligned pulses once, word unchanged.
REQ-032 SW @0x2 -> mem_misaligned=1 for one cycle, no write; SW @0x0 with DEPTH_WORDS=16 followed by a read @0x40 -> returns the same word (wrap).
REQ-033 Request during sweep (SW 0xFFFFFFFF @0x0 at cycle 3) -> ignored; after mem_busy falls, read @0x0 returns 0.
REQ-034 i_rst pulse low mid-sweep and mid-read -> mem_data=0 immediately, mem_busy=1, and the sweep restarts a full DEPTH_WORDS cycles.
